keycode_conditioner: RTL and testbench

KEYCODE_CONDITIONER -- requirements
Module: keycode_conditioner

---
 rtl/keyboard_pkg.sv | 26 ++
 rtl/frame_tick_gen.sv | 25 ++
 rtl/keycode_conditioner.sv | 131 +++++++++++++
 tb/tb_keycode_conditioner.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/keyboard_pkg.sv
`default_nettype none
// ============================================================================
// Module   : keyboard_pkg
// Purpose  : Movement keycodes and conditioner state encoding shared with the ball stage.
// Revision : 1.0
// ============================================================================
package keyboard_pkg;

  localparam logic [7:0] KEY_NONE = 8'h00;
  localparam logic [7:0] KEY_W    = 8'h1A;
  localparam logic [7:0] KEY_A    = 8'h04;
  localparam logic [7:0] KEY_S    = 8'h16;
  localparam logic [7:0] KEY_D    = 8'h07;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    CANDIDATE = 2'd1,
    HELD      = 2'd2
  } kc_state_e;

  function automatic logic is_move_key(input logic [7:0] code);
    return (code == KEY_W) || (code == KEY_A) || (code == KEY_S) || (code == KEY_D);
  endfunction

endpackage
`default_nettype wire

// File: rtl/frame_tick_gen.sv
`default_nettype none
// ============================================================================
// Module   : frame_tick_gen
// Purpose  : Registers vsync and flags its rising edge for one clock.
// Revision : 1.0
// ============================================================================
module frame_tick_gen (
  input  logic Clk,
  input  logic Reset,
  input  logic vsync,
  output logic frame_edge
);

  logic vsync_q;

  // Reset value of 1 keeps a vsync already high at release from counting as an edge.
  always_ff @(posedge Clk) begin
    if (Reset) vsync_q <= 1'b1;
    else       vsync_q <= vsync;
  end

  assign frame_edge = vsync & ~vsync_q;

endmodule
`default_nettype wire

// File: rtl/keycode_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : keycode_conditioner
// Purpose  : Picks the first movement key per frame and issues it once stable.
// Revision : 1.0
// ============================================================================
module keycode_conditioner
  import keyboard_pkg::*;
#(
  parameter int STABLE_FRAMES = 2
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        vsync,
  input  logic [31:0] keycode_raw,
  output logic [7:0]  keycode,
  output logic        key_valid,
  output logic        press_pulse,
  output logic        release_pulse
);

  localparam logic [4:0] SF_CMP = 5'(STABLE_FRAMES);
  localparam logic [3:0] SF_CNT = 4'(STABLE_FRAMES);

  logic       frame_edge;
  logic [7:0] sel;
  logic [4:0] cnt_inc;

  kc_state_e  state_q, state_d;
  logic [7:0] cand_q, cand_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] key_q, key_d;
  logic       valid_q, press_q, press_d, release_q, release_d;

  frame_tick_gen u_tick (
    .Clk        (Clk),
    .Reset      (Reset),
    .vsync      (vsync),
    .frame_edge (frame_edge)
  );

  // Scanning downward lets the lowest-numbered matching slot win.
  always_comb begin
    sel = KEY_NONE;
    for (int i = 3; i >= 0; i--) begin
      if (is_move_key(keycode_raw[i*8 +: 8])) sel = keycode_raw[i*8 +: 8];
    end
  end

  assign cnt_inc = {1'b0, cnt_q} + 5'd1;

  always_comb begin
    state_d   = state_q;
    cand_d    = cand_q;
    cnt_d     = cnt_q;
    key_d     = key_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    if (frame_edge) begin
      case (state_q)
        CANDIDATE: begin
          if (sel == KEY_NONE) begin
            state_d = IDLE;
            cnt_d   = 4'd0;
          end else if (sel == cand_q) begin
            if (cnt_inc >= SF_CMP) begin
              state_d = HELD;
              cnt_d   = SF_CNT;
              key_d   = cand_q;
              press_d = 1'b1;
            end else begin
              cnt_d = cnt_inc[3:0];
            end
          end else begin
            cand_d = sel;
            cnt_d  = 4'd1;
          end
        end
        default: begin
          // IDLE, and HELD once the held key has gone: withdraw, then treat sel as from IDLE.
          if (state_q != HELD || sel != cand_q) begin
            if (state_q == HELD) begin
              release_d = 1'b1;
              key_d     = KEY_NONE;
              state_d   = IDLE;
              cnt_d     = 4'd0;
            end
            if (sel != KEY_NONE) begin
              cand_d = sel;
              cnt_d  = 4'd1;
              if (STABLE_FRAMES == 1) begin
                state_d = HELD;
                key_d   = sel;
                press_d = 1'b1;
              end else begin
                state_d = CANDIDATE;
              end
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q   <= IDLE;
      cand_q    <= KEY_NONE;
      cnt_q     <= 4'd0;
      key_q     <= KEY_NONE;
      valid_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cand_q    <= cand_d;
      cnt_q     <= cnt_d;
      key_q     <= key_d;
      valid_q   <= (key_d != KEY_NONE);
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  assign keycode       = key_q;
  assign key_valid     = valid_q;
  assign press_pulse   = press_q;
  assign release_pulse = release_q;

endmodule
`default_nettype wire

// File: tb/tb_keycode_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : tb_keycode_conditioner
// Purpose  : Scoreboard bench for keycode_conditioner at STABLE_FRAMES 2 and 1.
// Revision : 1.0
// ============================================================================
module tb_keycode_conditioner;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        vsync = 1'b0;
  logic [31:0] keycode_raw = 32'h0;

  logic [7:0] k2, k1;
  logic       v2, v1, p2, p1, r2, r1;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [7:0] key;
    int         press;
    int         rel;
    bit         nozero;
    string      name;
  } exp_t;

  exp_t sb[$];

  always #5 Clk = ~Clk;

  keycode_conditioner #(.STABLE_FRAMES(2)) dut2 (
    .Clk(Clk), .Reset(Reset), .vsync(vsync), .keycode_raw(keycode_raw),
    .keycode(k2), .key_valid(v2), .press_pulse(p2), .release_pulse(r2)
  );

  keycode_conditioner #(.STABLE_FRAMES(1)) dut1 (
    .Clk(Clk), .Reset(Reset), .vsync(vsync), .keycode_raw(keycode_raw),
    .keycode(k1), .key_valid(v1), .press_pulse(p1), .release_pulse(r1)
  );

  task automatic do_reset();
    @(negedge Clk);
    Reset = 1'b1; vsync = 1'b0; keycode_raw = 32'h0;
    repeat (2) @(negedge Clk);
    Reset = 1'b0;
    @(negedge Clk);
  endtask

  // One frame: vsync rises with raw applied, raw is scrambled after the edge, then vsync falls.
  task automatic do_frame(input logic [31:0] raw, input int which, input logic [7:0] ekey,
                          input int epress, input int erel, input bit nozero, input string name);
    exp_t e;
    int np, nr, nz;
    logic [7:0] k;
    logic v;
    e.key = ekey; e.press = epress; e.rel = erel; e.nozero = nozero; e.name = name;
    sb.push_back(e);
    np = 0; nr = 0; nz = 0; k = 8'h0; v = 1'b0;
    keycode_raw = raw;
    vsync = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge Clk);
      if (i == 0) keycode_raw = 32'h1607_041A;
      if (i == 4) vsync = 1'b0;
      k = (which == 1) ? k1 : k2;
      v = (which == 1) ? v1 : v2;
      np += (which == 1) ? int'(p1) : int'(p2);
      nr += (which == 1) ? int'(r1) : int'(r2);
      nz += (k == 8'h00) ? 1 : 0;
    end
    e = sb.pop_front();
    n_checks++;
    if (k !== e.key) begin
      n_fail++;
      $display("FAIL %s keycode: got %h expected %h", e.name, k, e.key);
    end
    n_checks++;
    if (v !== (e.key != 8'h00)) begin
      n_fail++;
      $display("FAIL %s key_valid: got %b expected %b", e.name, v, (e.key != 8'h00));
    end
    n_checks++;
    if (np != e.press) begin
      n_fail++;
      $display("FAIL %s press_pulse count: got %0d expected %0d", e.name, np, e.press);
    end
    n_checks++;
    if (nr != e.rel) begin
      n_fail++;
      $display("FAIL %s release_pulse count: got %0d expected %0d", e.name, nr, e.rel);
    end
    if (e.nozero) begin
      n_checks++;
      if (nz != 0) begin
        n_fail++;
        $display("FAIL %s zero keycode cycles: got %0d expected 0", e.name, nz);
      end
    end
  endtask

  task automatic check_quiet(input string name);
    n_checks++;
    if ({k2, v2, p2, r2} !== 11'h0) begin
      n_fail++;
      $display("FAIL %s sf2 outputs: got k=%h v=%b p=%b r=%b expected all 0", name, k2, v2, p2, r2);
    end
    n_checks++;
    if ({k1, v1, p1, r1} !== 11'h0) begin
      n_fail++;
      $display("FAIL %s sf1 outputs: got k=%h v=%b p=%b r=%b expected all 0", name, k1, v1, p1, r1);
    end
  endtask

  task automatic test_reset();
    do_reset();
    check_quiet("reset");
  endtask

  task automatic test_debounce();
    do_reset();
    do_frame(32'h0000_001A, 0, 8'h00, 0, 0, 0, "deb_f1");
    do_frame(32'h0000_001A, 0, 8'h1A, 1, 0, 0, "deb_f2");
    for (int i = 3; i <= 6; i++)
      do_frame(32'h0000_001A, 0, 8'h1A, 0, 0, 1, $sformatf("deb_f%0d", i));
  endtask

  task automatic test_slot_priority();
    do_reset();
    do_frame(32'h0004_1A05, 0, 8'h00, 0, 0, 0, "prio_f1");
    do_frame(32'h0004_1A05, 0, 8'h1A, 1, 0, 0, "prio_f2");
    do_reset();
    do_frame(32'h2829_0511, 0, 8'h00, 0, 0, 0, "nomove_f1");
    do_frame(32'h2829_0511, 0, 8'h00, 0, 0, 0, "nomove_f2");
    do_frame(32'h0700_0000, 0, 8'h00, 0, 0, 0, "slot3_f1");
    do_frame(32'h0700_0000, 0, 8'h07, 1, 0, 0, "slot3_f2");
  endtask

  task automatic test_release();
    do_reset();
    do_frame(32'h0000_0007, 0, 8'h00, 0, 0, 0, "rel_f1");
    do_frame(32'h0000_0007, 0, 8'h07, 1, 0, 0, "rel_f2");
    do_frame(32'h0000_0000, 0, 8'h00, 0, 1, 0, "rel_drop");
    do_frame(32'h0000_0007, 0, 8'h00, 0, 0, 0, "rel_idle_again");
  endtask

  task automatic test_swap_sf1();
    do_reset();
    do_frame(32'h0000_0004, 1, 8'h04, 1, 0, 0, "swap_press");
    do_frame(32'h0000_0016, 1, 8'h16, 1, 1, 1, "swap_change");
    do_frame(32'h0000_0000, 1, 8'h00, 0, 1, 0, "swap_drop");
  endtask

  task automatic test_alternate();
    do_reset();
    for (int i = 0; i < 4; i++)
      do_frame((i % 2 == 0) ? 32'h0000_001A : 32'h0000_0016, 0, 8'h00, 0, 0, 0,
               $sformatf("alt_f%0d", i));
  endtask

  task automatic test_reset_midop();
    do_reset();
    do_frame(32'h0000_0007, 0, 8'h00, 0, 0, 0, "mid_f1");
    do_frame(32'h0000_0007, 0, 8'h07, 1, 0, 0, "mid_f2");
    @(negedge Clk);
    keycode_raw = 32'h0000_0007;
    vsync = 1'b1;
    Reset = 1'b1;
    @(negedge Clk);
    check_quiet("mid_in_reset");
    Reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge Clk);
      check_quiet($sformatf("mid_vsync_high_%0d", i));
    end
    vsync = 1'b0;
    repeat (2) @(negedge Clk);
    do_frame(32'h0000_0007, 0, 8'h00, 0, 0, 0, "mid_after_f1");
    do_frame(32'h0000_0007, 0, 8'h07, 1, 0, 0, "mid_after_f2");
  endtask

  initial begin
    test_reset();
    test_debounce();
    test_slot_priority();
    test_release();
    test_swap_sf1();
    test_alternate();
    test_reset_midop();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
